multiplier_control_taint_vec: RTL and testbench
===============================================

Name: multiplier_control_taint_vec

Overview:
- Parametrised successor to the sequential multiplier control FSM, with explicit state encoding and a busy/done handshake.
- Tracks taint per multiplier bit instead of one word-level flag. Taint rules are corrected: no overwritten assignments, and every output has a defined taint.
- Drives the shift-add datapath (multiplicand load, multiplier load, result clear/load/shift) and the matching per-output taint bits.

Parameters:
- WIDTH, 8, operand width in bits; must be >= 2.
- CW, $clog2(WIDTH), bit-counter width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a multiply; sampled only in IDLE.
- start_t  in  1  taint of start.
- multiplierReg  in  WIDTH  multiplier value from the datapath.
- multiplierReg_t  in  WIDTH  per-bit taint of multiplierReg.
- busy, busy_t  out  1  high in every state except IDLE; busy_t is its taint.
- productDone, productDone_t  out  1  one-cycle done pulse; productDone_t is its taint.
- mdld, mdld_t  out  1  load multiplicand register.
- mrld, mrld_t  out  1  load multiplier register.
- rsclear, rsclear_t  out  1  clear result register.
- rsload, rsload_t  out  1  add multiplicand into result register.
- rsshr, rsshr_t  out  1  shift result register right.

Behaviour:
- Reset: while rst=0, asynchronously force state=IDLE, bitCounter=0, state_t=0, cnt_t=0. All outputs and all taints read 0.
- States: IDLE=0, INIT=1, TEST=2, LOAD=3, SHIFT=4, DONE=5. Codes 6-7 go to IDLE.
- Outputs are decoded combinationally from the state (Moore); defaults are 0.
  - INIT asserts mdld, mrld, rsclear.
  - LOAD asserts rsload.
  - SHIFT asserts rsshr.
  - DONE asserts productDone.
- Transitions:
  - IDLE: go to INIT if start=1, else stay.
  - INIT: go to TEST; bitCounter<=0.
  - TEST: go to LOAD if multiplierReg[bitCounter]=1, else go to SHIFT.
  - LOAD: go to SHIFT.
  - SHIFT: bitCounter<=bitCounter+1. Go to DONE if bitCounter==WIDTH-1, else go to TEST.
  - DONE: go to IDLE.
- Latency: let E0 be the edge that samples start. INIT is cycle 1 after E0, and productDone is high in cycle 2 + sum over i of (2 + b_i), where b_i = multiplierReg[i].
  - WIDTH=4: done in cycle 10 for multiplierReg=0, cycle 14 for 0xF.
- start outside IDLE is ignored. No restart and no abort except reset.
- Reset asserted mid-operation: immediate return to IDLE, no productDone pulse. The datapath contents are don't-care.
- Taint state, updated every edge:
  - state_t:
    - IDLE: next = state_t | start_t.
    - TEST: next = state_t | cnt_t | multiplierReg_t[bitCounter].
    - SHIFT: next = state_t | cnt_t, because the end-of-count compare depends on the counter.
    - All other states: hold.
  - cnt_t:
    - INIT: next = state_t.
    - SHIFT: next = cnt_t | state_t.
    - All other states: hold.
  - Both taints are sticky until reset; returning to IDLE does not clear them.
- Every *_t output equals state_t, evaluated combinationally, including busy_t.

Optional Feature:
- Macro: MULT_SIGNED_EN.
- Defined:
  - Adds inputs signed_mode and signed_mode_t, and outputs rssub and rssub_t.
  - signed_mode is latched in INIT; signed_mode_t ORs into state_t on the IDLE->INIT edge.
  - In LOAD with bitCounter==WIDTH-1 and the latched signed_mode=1, assert rssub instead of rsload. rssub_t equals state_t.
- Undefined: none of these ports exist, and the MSB is always treated as an add.

Test Plan:
- WIDTH=4, multiplierReg=4'b0000, start pulse, no taint -> rsload never asserted; 4 rsshr pulses; productDone high in cycle 10 only; all *_t=0.
- WIDTH=4, multiplierReg=4'b1111 -> 4 rsload pulses, each immediately followed by rsshr; productDone in cycle 14; busy high for cycles 1-14.
- WIDTH=4, multiplierReg=4'b0101, multiplierReg_t=4'b0100 -> all *_t=0 through bit-1 processing. From the cycle after TEST of bit 2, all *_t=1, persisting into IDLE.
- start=1, start_t=1 -> all *_t=1 from INIT (cycle 1) onward. A second start pulse at cycle 5 is ignored (productDone count=1).
- rst driven low at cycle 6 mid-run, asynchronously between edges -> outputs and taints are 0 before the next edge; state is IDLE. After release, a new start completes normally.
- With MULT_SIGNED_EN, WIDTH=4, signed_mode=1, multiplierReg=4'b1001 -> rsload for bit 0, rssub (not rsload) for bit 3; productDone in cycle 12.

Source files
------------

// File: rtl/multiplier_control_taint_vec.sv
// Shift-add multiplier control FSM with a busy/done handshake and per-bit taint tracking.
// Optional signed MSB subtract is enabled by defining MULT_SIGNED_EN.
module multiplier_control_taint_vec #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             start_t,
  input  logic [WIDTH-1:0] multiplierReg,
  input  logic [WIDTH-1:0] multiplierReg_t,
`ifdef MULT_SIGNED_EN
  input  logic             signed_mode,
  input  logic             signed_mode_t,
  output logic             rssub,
  output logic             rssub_t,
`endif
  output logic             busy,
  output logic             busy_t,
  output logic             productDone,
  output logic             productDone_t,
  output logic             mdld,
  output logic             mdld_t,
  output logic             mrld,
  output logic             mrld_t,
  output logic             rsclear,
  output logic             rsclear_t,
  output logic             rsload,
  output logic             rsload_t,
  output logic             rsshr,
  output logic             rsshr_t
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    TEST  = 3'd2,
    LOAD  = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_e;

  state_e          state_reg, state_next;
  logic [CW-1:0]   bit_cnt_reg, bit_cnt_next;
  logic            state_t_reg, state_t_next;
  logic            cnt_t_reg, cnt_t_next;
  logic            last_bit;

`ifdef MULT_SIGNED_EN
  logic            signed_reg;
`endif

  assign last_bit = (bit_cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      state_t_reg <= 1'b0;
      cnt_t_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      state_t_reg <= state_t_next;
      cnt_t_reg   <= cnt_t_next;
    end
  end

`ifdef MULT_SIGNED_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      signed_reg <= 1'b0;
    end else if (state_reg == INIT) begin
      signed_reg <= signed_mode;
    end
  end
`endif

  // Next-state, counter and taint propagation.
  always_comb begin
    state_next   = IDLE;
    bit_cnt_next = bit_cnt_reg;
    state_t_next = state_t_reg;
    cnt_t_next   = cnt_t_reg;
    case (state_reg)
      IDLE: begin
        state_next   = start ? INIT : IDLE;
        state_t_next = state_t_reg | start_t;
`ifdef MULT_SIGNED_EN
        if (start) begin
          state_t_next = state_t_reg | start_t | signed_mode_t;
        end
`endif
      end
      INIT: begin
        state_next   = TEST;
        bit_cnt_next = '0;
        cnt_t_next   = state_t_reg;
      end
      TEST: begin
        state_next   = multiplierReg[bit_cnt_reg] ? LOAD : SHIFT;
        state_t_next = state_t_reg | cnt_t_reg | multiplierReg_t[bit_cnt_reg];
      end
      LOAD: begin
        state_next = SHIFT;
      end
      SHIFT: begin
        state_next   = last_bit ? DONE : TEST;
        bit_cnt_next = bit_cnt_reg + 1'b1;
        // End-of-count compare reads the counter, so its taint reaches control.
        state_t_next = state_t_reg | cnt_t_reg;
        cnt_t_next   = cnt_t_reg | state_t_reg;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Moore output decode; every control output shares the control-path taint.
  always_comb begin
    busy        = (state_reg != IDLE);
    productDone = (state_reg == DONE);
    mdld        = (state_reg == INIT);
    mrld        = (state_reg == INIT);
    rsclear     = (state_reg == INIT);
    rsshr       = (state_reg == SHIFT);
`ifdef MULT_SIGNED_EN
    rssub       = (state_reg == LOAD) && last_bit && signed_reg;
    rsload      = (state_reg == LOAD) && !(last_bit && signed_reg);
    rssub_t     = state_t_reg;
`else
    rsload      = (state_reg == LOAD);
`endif
    busy_t        = state_t_reg;
    productDone_t = state_t_reg;
    mdld_t        = state_t_reg;
    mrld_t        = state_t_reg;
    rsclear_t     = state_t_reg;
    rsload_t      = state_t_reg;
    rsshr_t       = state_t_reg;
  end

endmodule

// File: tb/tb_multiplier_control_taint_vec.sv
// Directed bench for multiplier_control_taint_vec at WIDTH=4; cycle 1 is INIT after the start edge.
module tb_multiplier_control_taint_vec;

  localparam int WIDTH = 4;
  localparam int NEVER = 99;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, start_t = 1'b0;
  logic [WIDTH-1:0] multiplierReg = '0, multiplierReg_t = '0;
  logic busy, busy_t, productDone, productDone_t, mdld, mdld_t, mrld, mrld_t;
  logic rsclear, rsclear_t, rsload, rsload_t, rsshr, rsshr_t;
`ifdef MULT_SIGNED_EN
  logic signed_mode = 1'b0, signed_mode_t = 1'b0;
  logic rssub, rssub_t;
`endif

  int n_cmp = 0;
  int n_err = 0;

  int n_load, n_shr, n_done, done_cyc, n_busy, busy_first, busy_last;
  int follow_err, taint_first, taint_bad, n_sub, sub_cyc;

  always #5 clk = ~clk;

  multiplier_control_taint_vec #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .start_t(start_t),
    .multiplierReg(multiplierReg), .multiplierReg_t(multiplierReg_t),
`ifdef MULT_SIGNED_EN
    .signed_mode(signed_mode), .signed_mode_t(signed_mode_t),
    .rssub(rssub), .rssub_t(rssub_t),
`endif
    .busy(busy), .busy_t(busy_t), .productDone(productDone), .productDone_t(productDone_t),
    .mdld(mdld), .mdld_t(mdld_t), .mrld(mrld), .mrld_t(mrld_t),
    .rsclear(rsclear), .rsclear_t(rsclear_t), .rsload(rsload), .rsload_t(rsload_t),
    .rsshr(rsshr), .rsshr_t(rsshr_t)
  );

  function automatic logic [6:0] out_vec();
    return {busy, productDone, mdld, mrld, rsclear, rsload, rsshr};
  endfunction

  function automatic logic [6:0] taint_vec();
    return {busy_t, productDone_t, mdld_t, mrld_t, rsclear_t, rsload_t, rsshr_t};
  endfunction

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0; start_t = 1'b0;
    multiplierReg = '0; multiplierReg_t = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Launches one multiply and profiles 20 cycles of outputs into the tally variables.
  task automatic run_mult(input logic [WIDTH-1:0] mr, input logic [WIDTH-1:0] mr_t,
                          input logic st_t, input int restart_c);
    logic prev_load;
    n_load = 0; n_shr = 0; n_done = 0; done_cyc = NEVER; n_busy = 0;
    busy_first = NEVER; busy_last = 0; follow_err = 0;
    taint_first = NEVER; taint_bad = 0; n_sub = 0; sub_cyc = NEVER;
    prev_load = 1'b0;
    @(negedge clk);
    multiplierReg = mr; multiplierReg_t = mr_t;
    start = 1'b1; start_t = st_t;
    @(posedge clk);
    #1;
    start = 1'b0; start_t = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (rsload) n_load++;
      if (rsshr) n_shr++;
      if (productDone) begin
        n_done++;
        if (done_cyc == NEVER) done_cyc = c;
      end
      if (busy) begin
        n_busy++;
        if (busy_first == NEVER) busy_first = c;
        busy_last = c;
      end
      if (prev_load && !rsshr) follow_err++;
      prev_load = rsload;
      if (taint_vec() == 7'h7F && taint_first == NEVER) taint_first = c;
      if (taint_first == NEVER ? (taint_vec() != 7'h00) : (taint_vec() != 7'h7F)) taint_bad++;
`ifdef MULT_SIGNED_EN
      if (rssub) begin
        n_sub++;
        if (sub_cyc == NEVER) sub_cyc = c;
      end
`endif
      start = (c == restart_c);
    end
    start = 1'b0;
  endtask

  initial begin
    int quiet_done;
    #12;
    check_val("reset_outputs", int'(out_vec()), 0);
    check_val("reset_taints", int'(taint_vec()), 0);
    @(negedge clk);
    rst = 1'b1;

    // Multiplier 0: shifts only.
    run_mult(4'b0000, 4'b0000, 1'b0, 0);
    check_val("m0_loads", n_load, 0);
    check_val("m0_shifts", n_shr, 4);
    check_val("m0_done_count", n_done, 1);
    check_val("m0_done_cycle", done_cyc, 10);
    check_val("m0_busy_cycles", n_busy, 10);
    check_val("m0_taint_first", taint_first, NEVER);
    check_val("m0_taint_bad", taint_bad, 0);

    // Multiplier F: every bit loads then shifts.
    do_reset();
    run_mult(4'b1111, 4'b0000, 1'b0, 0);
    check_val("mf_loads", n_load, 4);
    check_val("mf_shifts", n_shr, 4);
    check_val("mf_load_then_shift", follow_err, 0);
    check_val("mf_done_cycle", done_cyc, 14);
    check_val("mf_busy_first", busy_first, 1);
    check_val("mf_busy_last", busy_last, 14);
    check_val("mf_busy_cycles", n_busy, 14);

    // Tainted bit 2 of multiplier 0101.
    do_reset();
    run_mult(4'b0101, 4'b0100, 1'b0, 0);
    check_val("m5_loads", n_load, 2);
    check_val("m5_done_cycle", done_cyc, 12);
    check_val("m5_taint_first", taint_first, 8);
    check_val("m5_taint_bad", taint_bad, 0);
    check_val("m5_taint_idle", int'(taint_vec()), 8'h7F);

    // Tainted start, with an ignored second start at cycle 5.
    do_reset();
    run_mult(4'b0011, 4'b0000, 1'b1, 5);
    check_val("st_taint_first", taint_first, 1);
    check_val("st_taint_bad", taint_bad, 0);
    check_val("st_done_count", n_done, 1);
    check_val("st_done_cycle", done_cyc, 12);

    // Asynchronous reset in cycle 6 of a tainted run.
    do_reset();
    @(negedge clk);
    multiplierReg = 4'b1111; start = 1'b1; start_t = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; start_t = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_val("rst_pre_busy", int'(busy), 1);
    check_val("rst_pre_taints", int'(taint_vec()), 8'h7F);
    #2;
    rst = 1'b0;
    #1;
    check_val("rst_async_outputs", int'(out_vec()), 0);
    check_val("rst_async_taints", int'(taint_vec()), 0);
    @(negedge clk);
    rst = 1'b1;
    quiet_done = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (productDone || busy) quiet_done++;
    end
    check_val("rst_no_activity", quiet_done, 0);
    run_mult(4'b0110, 4'b0000, 1'b0, 0);
    check_val("post_rst_done_cycle", done_cyc, 12);
    check_val("post_rst_loads", n_load, 2);
    check_val("post_rst_taint_first", taint_first, NEVER);

`ifdef MULT_SIGNED_EN
    do_reset();
    signed_mode = 1'b1;
    run_mult(4'b1001, 4'b0000, 1'b0, 0);
    signed_mode = 1'b0;
    check_val("sg_loads", n_load, 1);
    check_val("sg_subs", n_sub, 1);
    check_val("sg_sub_cycle", sub_cyc, 10);
    check_val("sg_done_cycle", done_cyc, 12);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
